// File: rtl/dice_pkg.sv
// Shared dice definitions: die/sum widths, die range, roll FSM encoding.
// Also imported by the downstream craps game FSM.
package dice_pkg;

   localparam int DIE_W = 3;
   localparam int SUM_W = 4;

   localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
   localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ROLLING = 2'd1,
      LATCH   = 2'd2
   } roll_state_e;

   // Next die value: out-of-range values recover to DIE_MIN regardless of adv.
   function automatic logic [DIE_W-1:0] next_die(input logic [DIE_W-1:0] cur,
                                                 input logic              adv);
      logic [DIE_W-1:0] nxt;
      if ((cur < DIE_MIN) || (cur > DIE_MAX)) begin
         nxt = DIE_MIN;
      end else if (!adv) begin
         nxt = cur;
      end else if (cur == DIE_MAX) begin
         nxt = DIE_MIN;
      end else begin
         nxt = cur + 3'd1;
      end
      return nxt;
   endfunction

   function automatic logic [SUM_W-1:0] die_sum(input logic [DIE_W-1:0] a,
                                                input logic [DIE_W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stable-count debounce for the raw roll button.
// db_roll changes only after the synchronised level has differed for DEBOUNCE_CYCLES cycles.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DB_W            = 5
) (
   input  logic clock,
   input  logic reset,
   input  logic roll,
   output logic db_roll
);

   logic            sync1_q, sync1_d;
   logic            roll_s_q, roll_s_d;
   logic            db_roll_q, db_roll_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   always_comb begin
      sync1_d   = roll;
      roll_s_d  = sync1_q;
      db_roll_d = db_roll_q;
      db_cnt_d  = '0;
      // Any cycle where roll_s agrees with db_roll restarts the stability count.
      if (roll_s_q != db_roll_q) begin
         if (db_cnt_q == DB_LAST) begin
            db_roll_d = roll_s_q;
            db_cnt_d  = '0;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         roll_s_q  <= 1'b0;
         db_roll_q <= 1'b0;
         db_cnt_q  <= '0;
      end else begin
         sync1_q   <= sync1_d;
         roll_s_q  <= roll_s_d;
         db_roll_q <= db_roll_d;
         db_cnt_q  <= db_cnt_d;
      end
   end

   assign db_roll = db_roll_q;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Roll-button front end for the craps game: free-running die pair, frozen on release.
// roll_valid is a one-cycle pulse (no ready): die1/die2/roll_sum take new values exactly then.
module dice_roll_ctrl
   import dice_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DB_W            = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             roll,
   output logic [DIE_W-1:0] die1,
   output logic [DIE_W-1:0] die2,
   output logic [SUM_W-1:0] roll_sum,
   output logic             roll_valid,
   output logic             rolling
);

   logic db_roll;

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_W            (DB_W)
   ) u_debounce (
      .clock   (clock),
      .reset   (reset),
      .roll    (roll),
      .db_roll (db_roll)
   );

   logic [DIE_W-1:0] cnt_a_q, cnt_a_d;
   logic [DIE_W-1:0] cnt_b_q, cnt_b_d;

   always_comb begin
      cnt_a_d = next_die(cnt_a_q, 1'b1);
      cnt_b_d = next_die(cnt_b_q, cnt_a_q == DIE_MAX);
   end

   roll_state_e      state_q, state_d;
   logic [DIE_W-1:0] die1_q, die1_d;
   logic [DIE_W-1:0] die2_q, die2_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic             valid_q, valid_d;
   logic             rolling_q, rolling_d;

   always_comb begin
      state_d = state_q;
      die1_d  = die1_q;
      die2_d  = die2_q;
      sum_d   = sum_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (db_roll) state_d = ROLLING;
         end
         ROLLING: begin
            if (!db_roll) state_d = LATCH;
         end
         LATCH: begin
            die1_d  = cnt_a_q;
            die2_d  = cnt_b_q;
            sum_d   = die_sum(cnt_a_q, cnt_b_q);
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Registered from the next state so rolling tracks state_q cycle for cycle.
      rolling_d = (state_d == ROLLING);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_a_q   <= DIE_MIN;
         cnt_b_q   <= DIE_MIN;
         state_q   <= IDLE;
         die1_q    <= DIE_MIN;
         die2_q    <= DIE_MIN;
         sum_q     <= 4'd2;
         valid_q   <= 1'b0;
         rolling_q <= 1'b0;
      end else begin
         cnt_a_q   <= cnt_a_d;
         cnt_b_q   <= cnt_b_d;
         state_q   <= state_d;
         die1_q    <= die1_d;
         die2_q    <= die2_d;
         sum_q     <= sum_d;
         valid_q   <= valid_d;
         rolling_q <= rolling_d;
      end
   end

   assign die1       = die1_q;
   assign die2       = die2_q;
   assign roll_sum   = sum_q;
   assign roll_valid = valid_q;
   assign rolling    = rolling_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl with DEBOUNCE_CYCLES=16.
// A small die-pair model runs beside the DUT and supplies the expected latched values.
module tb_dice_roll_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       roll  = 1'b0;
   logic [2:0] die1, die2;
   logic [3:0] roll_sum;
   logic       roll_valid, rolling;

   int checks   = 0;
   int failures = 0;

   dice_roll_ctrl #(.DEBOUNCE_CYCLES(16), .DB_W(5)) dut (
      .clock      (clock),
      .reset      (reset),
      .roll       (roll),
      .die1       (die1),
      .die2       (die2),
      .roll_sum   (roll_sum),
      .roll_valid (roll_valid),
      .rolling    (rolling)
   );

   always #5 clock = ~clock;

   // Die-pair model: last_a/last_b hold the pair present just before the latest edge.
   int ma = 1, mb = 1, last_a = 1, last_b = 1;
   always @(posedge clock) begin
      last_a = ma;
      last_b = mb;
      if (reset) begin
         ma = 1;
         mb = 1;
      end else if (ma == 6) begin
         ma = 1;
         mb = (mb == 6) ? 1 : mb + 1;
      end else begin
         ma = ma + 1;
      end
   end

   // Event counters sampled on the falling edge, away from output changes.
   int valid_cnt = 0, rise_cnt = 0;
   logic rolling_prev = 1'b0;
   always @(negedge clock) begin
      if (roll_valid === 1'b1) valid_cnt++;
      if (rolling === 1'b1 && rolling_prev !== 1'b1) rise_cnt++;
      rolling_prev = rolling;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_rolling(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (rolling !== 1'b1 && n < 60);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (roll_valid !== 1'b1 && n < 60);
   endtask

   int n, v0, r0, k, guard;
   logic [2:0] d1_hold, d2_hold;

   initial begin
      // 1: reset held two edges
      reset = 1'b1;
      roll  = 1'b0;
      tick();
      tick();
      chk("rst_die1", die1, 1);
      chk("rst_die2", die2, 1);
      chk("rst_sum", roll_sum, 2);
      chk("rst_valid", roll_valid, 0);
      chk("rst_rolling", rolling, 0);
      reset = 1'b0;
      repeat (3) tick();

      // 2: clean 40-cycle press; edges counted include the first edge seeing the change
      v0 = valid_cnt;
      roll = 1'b1;
      wait_rolling(n);
      chk("t2_rise_lat", n, 19);
      repeat (21) tick();
      roll = 1'b0;
      wait_valid(n);
      chk("t2_valid_lat", n, 20);
      chk("t2_die1", die1, last_a);
      chk("t2_die2", die2, last_b);
      chk("t2_sum", roll_sum, last_a + last_b);
      chk("t2_rolling_low", rolling, 0);
      tick();
      chk("t2_valid_pulse", roll_valid, 0);
      chk("t2_valid_count", valid_cnt - v0, 1);

      // 3: 5-cycle glitch is rejected
      repeat (5) tick();
      v0 = valid_cnt;
      r0 = rise_cnt;
      d1_hold = die1;
      d2_hold = die2;
      roll = 1'b1;
      repeat (5) tick();
      roll = 1'b0;
      repeat (40) tick();
      chk("t3_no_rise", rise_cnt - r0, 0);
      chk("t3_no_valid", valid_cnt - v0, 0);
      chk("t3_die1_hold", die1, d1_hold);
      chk("t3_die2_hold", die2, d2_hold);

      // 4: bouncing press (toggle every 3 cycles for 30), then 40 steady high
      v0 = valid_cnt;
      r0 = rise_cnt;
      for (int i = 0; i < 10; i++) begin
         roll = (i % 2 == 0);
         repeat (3) tick();
      end
      roll = 1'b1;
      repeat (40) tick();
      roll = 1'b0;
      wait_valid(n);
      chk("t4_valid_lat", n, 20);
      chk("t4_die1", die1, last_a);
      chk("t4_die2", die2, last_b);
      chk("t4_sum", roll_sum, last_a + last_b);
      repeat (5) tick();
      chk("t4_one_rise", rise_cnt - r0, 1);
      chk("t4_one_valid", valid_cnt - v0, 1);

      // 5: release timed so the latch edge (20th after release) sees pair (6,6)
      roll = 1'b1;
      repeat (25) tick();
      guard = 0;
      k = (mb - 1) * 6 + (ma - 1);
      while (k != 16 && guard < 40) begin
         tick();
         guard++;
         k = (mb - 1) * 6 + (ma - 1);
      end
      chk("t5_align", k, 16);
      roll = 1'b0;
      wait_valid(n);
      chk("t5_valid_lat", n, 20);
      chk("t5_die1", die1, 6);
      chk("t5_die2", die2, 6);
      chk("t5_sum", roll_sum, 12);
      chk("t5_cnt_a_wrap", dut.cnt_a_q, 1);
      chk("t5_cnt_b_wrap", dut.cnt_b_q, 1);
      repeat (5) tick();

      // 6: reset pulse mid-roll with the button still held
      roll = 1'b1;
      wait_rolling(n);
      chk("t6_rise_lat", n, 19);
      repeat (3) tick();
      v0 = valid_cnt;
      reset = 1'b1;
      tick();
      chk("t6_rst_die1", die1, 1);
      chk("t6_rst_die2", die2, 1);
      chk("t6_rst_sum", roll_sum, 2);
      chk("t6_rst_rolling", rolling, 0);
      chk("t6_rst_valid", roll_valid, 0);
      reset = 1'b0;
      // rising on the 19th edge after the reset edge, 18 after the first reset-free edge
      wait_rolling(n);
      chk("t6_rerise_lat", n, 19);
      chk("t6_no_valid", valid_cnt - v0, 0);
      repeat (5) tick();
      roll = 1'b0;
      wait_valid(n);
      chk("t6_valid_lat", n, 20);
      chk("t6_die1", die1, last_a);
      chk("t6_die2", die2, last_b);
      chk("t6_sum", roll_sum, last_a + last_b);
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
